// File: rtl/dqn_pkg.sv
// Shared types and constants for the DQN training controllers.
// Holds the scheduler state encoding, default word widths and fp32 constants.
package dqn_pkg;

    localparam int DQN_DATA_WIDTH   = 32;
    localparam int DQN_ACTION_WIDTH = 2;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_LOAD,
        S_SETTLE,
        S_FETCH,
        S_WAIT_RB,
        S_ISSUE,
        S_WAIT_NET,
        S_UPDATE,
        S_WAIT_UPD
    } sched_state_e;

endpackage

// File: rtl/sched_watchdog.sv
// Cycle counter that flags the LIMIT-th consecutive enabled cycle.
// The owner clears it on every state change; it saturates at the limit.
module sched_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign hit_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !hit_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dqn_train_scheduler.sv
// Training-run sequencer: weight load, replay fetch, per-sample issue to the
// network, and periodic soft target updates, with a done-handshake watchdog.
module dqn_train_scheduler
    import dqn_pkg::*;
#(
    parameter int DATA_WIDTH      = DQN_DATA_WIDTH,
    parameter int ACTION_WIDTH    = DQN_ACTION_WIDTH,
    parameter int BATCH_SIZE      = 16,
    parameter int UPDATE_PERIOD   = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int WATCHDOG_CYCLES = 4096,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_load_weight_done,
    output logic                    o_rb_req,
    input  logic                    i_rb_valid,
    input  logic [DATA_WIDTH-1:0]   i_rb_state_0,
    input  logic [DATA_WIDTH-1:0]   i_rb_state_1,
    input  logic [ACTION_WIDTH-1:0] i_rb_action,
    input  logic [DATA_WIDTH-1:0]   i_rb_reward,
    input  logic [DATA_WIDTH-1:0]   i_rb_next_state_0,
    input  logic [DATA_WIDTH-1:0]   i_rb_next_state_1,
    input  logic                    i_rb_done,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_current_state_0,
    output logic [DATA_WIDTH-1:0]   o_current_state_1,
    output logic [ACTION_WIDTH-1:0] o_action,
    output logic [DATA_WIDTH-1:0]   o_reward,
    output logic [DATA_WIDTH-1:0]   o_next_state_0,
    output logic [DATA_WIDTH-1:0]   o_next_state_1,
    output logic                    o_done,
    output logic                    o_train_mode,
    output logic                    o_update_request,
    input  logic                    i_main_net_done,
    input  logic                    i_update_done,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_batch_count,
    output logic                    o_error
);
    localparam int TW = 5 * DATA_WIDTH + ACTION_WIDTH + 1;
    localparam int SW = $clog2(BATCH_SIZE + 1);
    localparam int UW = $clog2(UPDATE_PERIOD + 1);

    sched_state_e         state_q, state_d;
    logic                 stop_q, stop_d, train_q, train_d, err_q, err_d;
    logic                 rb_req_q, rb_req_d, valid_q, valid_d, upd_q, upd_d;
    logic [CNT_WIDTH-1:0] batch_q, batch_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [UW-1:0]        bmod_q, bmod_d;
    logic [TW-1:0]        tup_q;
    logic                 stop_any, capture, state_chg, wd_en, wd_hit, settle_hit;

    assign stop_any  = stop_q | i_stop;
    assign capture   = (state_q == S_WAIT_RB) && i_rb_valid;
    assign state_chg = (state_d != state_q);
    assign wd_en     = (state_q == S_WAIT_LOAD) || (state_q == S_WAIT_RB) ||
                       (state_q == S_WAIT_NET)  || (state_q == S_WAIT_UPD);

    sched_watchdog #(.LIMIT(WATCHDOG_CYCLES)) u_wd (
        .clk(clk), .rst_n(rst_n), .clr_i(state_chg), .en_i(wd_en), .hit_o(wd_hit)
    );

    // Same counter gives the post-update quiet time for the network FSM.
    sched_watchdog #(.LIMIT(SETTLE_CYCLES)) u_settle (
        .clk(clk), .rst_n(rst_n), .clr_i(state_chg), .en_i(state_q == S_SETTLE),
        .hit_o(settle_hit)
    );

    always_comb begin
        state_d  = state_q;
        stop_d   = stop_q | i_stop;
        train_d  = train_q;
        err_d    = err_q;
        batch_d  = batch_q;
        sample_d = sample_q;
        bmod_d   = bmod_q;
        rb_req_d = 1'b0;
        valid_d  = 1'b0;
        upd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (i_start) begin
                    err_d    = 1'b0;
                    batch_d  = '0;
                    sample_d = '0;
                    bmod_d   = '0;
                    state_d  = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                if (i_load_weight_done) begin
                    train_d = 1'b1;
                    state_d = S_SETTLE;
                end else if (stop_any) begin
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: if (settle_hit) state_d = S_FETCH;
            S_FETCH: begin
                rb_req_d = 1'b1;
                state_d  = S_WAIT_RB;
            end
            S_WAIT_RB: begin
                if (i_rb_valid) begin
                    state_d = S_ISSUE;
                end else if (stop_any) begin
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                valid_d = 1'b1;
                state_d = S_WAIT_NET;
            end
            S_WAIT_NET: begin
                if (i_main_net_done) begin
                    state_d = stop_any ? S_IDLE : S_FETCH;
                    if (sample_q == SW'(BATCH_SIZE - 1)) begin
                        sample_d = '0;
                        batch_d  = batch_q + CNT_WIDTH'(1);
                        if (bmod_q == UW'(UPDATE_PERIOD - 1)) begin
                            bmod_d  = '0;
                            state_d = S_UPDATE;
                        end else begin
                            bmod_d = bmod_q + UW'(1);
                        end
                    end else begin
                        sample_d = sample_q + SW'(1);
                    end
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                upd_d   = 1'b1;
                state_d = S_WAIT_UPD;
            end
            S_WAIT_UPD: begin
                if (i_update_done) begin
                    state_d = stop_any ? S_IDLE : S_SETTLE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) train_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stop_q   <= 1'b0;
            train_q  <= 1'b0;
            err_q    <= 1'b0;
            batch_q  <= '0;
            sample_q <= '0;
            bmod_q   <= '0;
            rb_req_q <= 1'b0;
            valid_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stop_q   <= stop_d;
            train_q  <= train_d;
            err_q    <= err_d;
            batch_q  <= batch_d;
            sample_q <= sample_d;
            bmod_q   <= bmod_d;
            rb_req_q <= rb_req_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
        end
    end

    // Tuple holds from capture until the next accepted replay word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tup_q <= '0;
        else if (capture) tup_q <= {i_rb_state_0, i_rb_state_1, i_rb_action, i_rb_reward,
                                    i_rb_next_state_0, i_rb_next_state_1, i_rb_done};
    end

    assign {o_current_state_0, o_current_state_1, o_action, o_reward,
            o_next_state_0, o_next_state_1, o_done} = tup_q;

    assign o_rb_req         = rb_req_q;
    assign o_valid          = valid_q;
    assign o_update_request = upd_q;
    assign o_train_mode     = train_q;
    assign o_error          = err_q;
    assign o_batch_count    = batch_q;
    assign o_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_dqn_train_scheduler.sv
// Randomized bench: plays replay buffer, network and update engine, and
// checks the scheduler against a sample/batch/update counting model.
module tb_dqn_train_scheduler;
    import dqn_pkg::*;

    localparam int BS = 2, UP = 3, SC = 2, WD = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_start = 0, i_stop = 0, i_load_weight_done = 0, i_rb_valid = 0, i_rb_done = 0;
    logic i_main_net_done = 0, i_update_done = 0;
    logic [31:0] i_rb_state_0 = 0, i_rb_state_1 = 0, i_rb_reward = 0;
    logic [31:0] i_rb_next_state_0 = 0, i_rb_next_state_1 = 0;
    logic [1:0]  i_rb_action = 0;
    logic o_rb_req, o_valid, o_done, o_train_mode, o_update_request, o_busy, o_error;
    logic [31:0] o_current_state_0, o_current_state_1, o_reward, o_next_state_0, o_next_state_1;
    logic [1:0]  o_action;
    logic [15:0] o_batch_count;

    int checks = 0, errors = 0;
    int samples_m = 0, batches_m = 0, bmod_m = 0;

    dqn_train_scheduler #(
        .DATA_WIDTH(32), .ACTION_WIDTH(2), .BATCH_SIZE(BS), .UPDATE_PERIOD(UP),
        .SETTLE_CYCLES(SC), .WATCHDOG_CYCLES(WD), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_load_weight_done(i_load_weight_done), .o_rb_req(o_rb_req), .i_rb_valid(i_rb_valid),
        .i_rb_state_0(i_rb_state_0), .i_rb_state_1(i_rb_state_1), .i_rb_action(i_rb_action),
        .i_rb_reward(i_rb_reward), .i_rb_next_state_0(i_rb_next_state_0),
        .i_rb_next_state_1(i_rb_next_state_1), .i_rb_done(i_rb_done), .o_valid(o_valid),
        .o_current_state_0(o_current_state_0), .o_current_state_1(o_current_state_1),
        .o_action(o_action), .o_reward(o_reward), .o_next_state_0(o_next_state_0),
        .o_next_state_1(o_next_state_1), .o_done(o_done), .o_train_mode(o_train_mode),
        .o_update_request(o_update_request), .i_main_net_done(i_main_net_done),
        .i_update_done(i_update_done), .o_busy(o_busy), .o_batch_count(o_batch_count),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel 0: wait for o_rb_req, sel 1: wait for o_update_request. n = ticks taken.
    task automatic wait_pulse(input string tag, input int sel, input bit spur, output int n);
        bit stray = 0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            if (spur) begin
                i_update_done   = ($urandom_range(0, 1) == 1);
                i_main_net_done = ($urandom_range(0, 1) == 1);
            end
            tick();
            i_update_done = 0; i_main_net_done = 0;
            if (sel == 0 ? o_rb_req : o_update_request) begin
                n = k;
                break;
            end
            stray |= o_valid | (sel == 0 ? o_update_request : o_rb_req);
        end
        chk({tag, "_stray"}, 64'(stray), 0);
        chk({tag, "_seen"}, 64'(n > 0), 1);
    endtask

    task automatic quiet(input string tag);
        bit seen = 0;
        repeat (8) begin
            tick();
            seen |= o_rb_req | o_valid | o_update_request;
        end
        chk({tag, "_quiet"}, 64'(seen), 0);
        chk({tag, "_idle"}, 64'(o_busy), 0);
    endtask

    task automatic start_run();
        int n;
        i_start = 1; tick(); i_start = 0;
        samples_m = 0; batches_m = 0; bmod_m = 0;
        chk("start_err_clr", 64'(o_error), 0);
        chk("start_busy", 64'(o_busy), 1);
        chk("start_bcnt", 64'(o_batch_count), 0);
        repeat ($urandom_range(1, 5)) tick();
        chk("train_pre_load", 64'(o_train_mode), 0);
        i_load_weight_done = 1; tick(); i_load_weight_done = 0;
        chk("train_rise", 64'(o_train_mode), 1);
        wait_pulse("load_fetch", 0, 1, n);
        chk("load_settle_gap", 64'(n >= SC + 1), 1);
    endtask

    task automatic do_sample(input bit stop_net, input bit wd_kill, input bit at_limit,
                             input bit stop_rb, output bit ended);
        logic [31:0] s0, s1, rw, n0, n1;
        logic [1:0]  ac;
        logic        dn;
        bit          upd = 0;
        int          n;
        ended = 0;
        repeat ($urandom_range(0, 3)) tick();
        if (stop_rb) begin
            i_stop = 1; tick(); i_stop = 0;
            chk("stop_rb_idle", 64'(o_busy), 0);
            chk("stop_rb_train", 64'(o_train_mode), 0);
            ended = 1;
            return;
        end
        s0 = ($urandom_range(0, 1) == 1) ? FP32_ONE : $urandom;
        s1 = $urandom; rw = $urandom; n0 = $urandom; n1 = $urandom;
        ac = 2'($urandom_range(0, 3)); dn = 1'($urandom_range(0, 1));
        i_rb_state_0 = s0; i_rb_state_1 = s1; i_rb_reward = rw; i_rb_action = ac;
        i_rb_next_state_0 = n0; i_rb_next_state_1 = n1; i_rb_done = dn;
        i_rb_valid = 1; tick(); i_rb_valid = 0;
        i_rb_state_0 = $urandom; i_rb_reward = $urandom; i_rb_next_state_1 = $urandom;
        chk("valid_early", 64'(o_valid), 0);
        tick();
        chk("valid_lat2", 64'(o_valid), 1);
        chk("tup_s0", 64'(o_current_state_0), 64'(s0));
        chk("tup_s1", 64'(o_current_state_1), 64'(s1));
        chk("tup_rew", 64'(o_reward), 64'(rw));
        chk("tup_ns", {o_next_state_0, o_next_state_1}, {n0, n1});
        chk("tup_act_done", 64'({o_action, o_done}), 64'({ac, dn}));
        i_stop = stop_net; i_start = ($urandom_range(0, 3) == 0);
        tick();
        i_stop = 0; i_start = 0;
        chk("valid_pulse", 64'(o_valid), 0);
        chk("tup_hold", 64'(o_current_state_0), 64'(s0));
        if (wd_kill) begin
            repeat (WD - 2) tick();
            chk("wd_early", 64'(o_error), 0);
            chk("wd_busy", 64'(o_busy), 1);
            tick();
            chk("wd_err", 64'(o_error), 1);
            chk("wd_idle", 64'(o_busy), 0);
            chk("wd_train", 64'(o_train_mode), 0);
            ended = 1;
            return;
        end
        if (at_limit) repeat (WD - 2) tick();
        else          repeat ($urandom_range(0, 8)) tick();
        i_main_net_done = 1; tick(); i_main_net_done = 0;
        samples_m++;
        if (samples_m == BS) begin
            samples_m = 0;
            batches_m++;
            bmod_m++;
            if (bmod_m == UP) begin
                bmod_m = 0;
                upd = 1;
            end
        end
        chk("batch_cnt", 64'(o_batch_count), 64'(batches_m));
        chk("no_err", 64'(o_error), 0);
        if (upd) begin
            wait_pulse("upd", 1, 0, n);
            tick();
            chk("upd_pulse", 64'(o_update_request), 0);
            repeat ($urandom_range(0, 4)) tick();
            i_update_done = 1; tick(); i_update_done = 0;
            if (!stop_net) begin
                wait_pulse("upd_fetch", 0, 1, n);
                chk("upd_settle_gap", 64'(n >= SC + 1), 1);
                return;
            end
        end else if (!stop_net) begin
            wait_pulse("fetch", 0, 1, n);
            return;
        end
        chk("stop_idle", 64'(o_busy), 0);
        chk("stop_train", 64'(o_train_mode), 0);
        ended = 1;
    endtask

    task automatic run(input string tag, input int nsamp, input int stop_at, input int wd_at,
                       input int lim_at, input int stoprb_at);
        bit ended = 0;
        start_run();
        for (int k = 1; k <= nsamp; k++) begin
            do_sample(k == stop_at, k == wd_at, k == lim_at, k == stoprb_at, ended);
            if (ended) break;
        end
        chk({tag, "_ended"}, 64'(ended), 1);
        quiet(tag);
    endtask

    initial begin
        i_start = 1;
        repeat (3) tick();
        chk("rst_outs", 64'({o_rb_req, o_valid, o_update_request, o_train_mode, o_error}), 0);
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_bcnt", 64'(o_batch_count), 0);
        chk("rst_tuple", {o_current_state_0, o_reward}, 0);
        i_start = 0; rst_n = 1;
        tick();

        run("r0_stop_net", 7, 7, 0, 0, 0);
        run("r1_watchdog", 5, 0, 3, 0, 0);
        run("r2_limit_stoprb", 7, 0, 0, 2, 7);
        run("r3_stop_at_upd", 12, 12, 0, 0, 0);

        // Async reset while waiting on the replay buffer.
        start_run();
        repeat (2) tick();
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 64'(o_busy), 0);
        chk("arst_train", 64'(o_train_mode), 0);
        @(posedge clk);
        #1 rst_n = 1;
        quiet("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
